// File: rtl/keyboard_voice_allocator.sv
// rtl/keyboard_voice_allocator.sv - PS/2 make/break parser and polyphonic voice allocator with timed release
// Optional VOICE_STEAL_EN: when every voice is gated, a new key steals voices round-robin instead of raising overflow.
module keyboard_voice_allocator #(
    parameter int          NUM_VOICES     = 4,
    parameter logic [31:0] AMP_ON         = 32'd5000000,
    parameter int          RELEASE_CYCLES = 2500000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [7:0]              keyboard_data,
    input  logic                    data_received_en,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_busy,
    output logic [8*NUM_VOICES-1:0] voice_code,
    output logic                    overflow,
    output logic [31:0]             Amplitude
);
    localparam int CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [CW-1:0] REL_LOAD = CW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {P_IDLE, P_BREAK, P_EXT, P_EXT_BRK} parse_t;
    parse_t state, state_next;
    logic   make_ev, break_ev;
    logic   is_f0, is_e0;

    assign is_f0 = (keyboard_data == 8'hF0);
    assign is_e0 = (keyboard_data == 8'hE0);

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= P_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        make_ev    = 1'b0;
        break_ev   = 1'b0;
        if (data_received_en) begin
            case (state)
                P_IDLE: begin
                    if (is_f0)      state_next = P_BREAK;
                    else if (is_e0) state_next = P_EXT;
                    else            make_ev    = 1'b1;
                end
                P_BREAK: begin
                    if (is_e0) state_next = P_EXT;
                    else if (!is_f0) begin
                        break_ev   = 1'b1;
                        state_next = P_IDLE;
                    end
                end
                P_EXT: begin
                    if (is_f0)       state_next = P_EXT_BRK;
                    else if (!is_e0) state_next = P_IDLE;
                end
                P_EXT_BRK: begin
                    if (!is_f0 && !is_e0) state_next = P_IDLE;
                end
                default: state_next = P_IDLE;
            endcase
        end
    end

    logic [CW-1:0] rel_cnt [NUM_VOICES];
    logic          gated_hit, rel_hit, idle_found, rel_found;
    logic [IW-1:0] gated_idx, rel_hit_idx, idle_idx, rel_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        gated_hit   = 1'b0;
        rel_hit     = 1'b0;
        idle_found  = 1'b0;
        rel_found   = 1'b0;
        gated_idx   = '0;
        rel_hit_idx = '0;
        idle_idx    = '0;
        rel_idx     = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && voice_code[8*i +: 8] == keyboard_data) begin
                gated_hit = 1'b1;
                gated_idx = IW'(i);
            end
            if (voice_busy[i] && !voice_gate[i] && voice_code[8*i +: 8] == keyboard_data) begin
                rel_hit     = 1'b1;
                rel_hit_idx = IW'(i);
            end
            if (!voice_busy[i]) begin
                idle_found = 1'b1;
                idle_idx   = IW'(i);
            end
            if (voice_busy[i] && !voice_gate[i]) begin
                rel_found = 1'b1;
                rel_idx   = IW'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [IW-1:0] steal_ptr;
`endif
    logic          alloc_en, load_code, drop, steal_adv;
    logic [IW-1:0] slot;

    always_comb begin
        alloc_en  = 1'b0;
        load_code = 1'b0;
        drop      = 1'b0;
        steal_adv = 1'b0;
        slot      = '0;
        if (make_ev && !gated_hit) begin
            if (rel_hit) begin
                alloc_en = 1'b1;
                slot     = rel_hit_idx;
            end else if (idle_found) begin
                alloc_en  = 1'b1;
                load_code = 1'b1;
                slot      = idle_idx;
            end else if (rel_found) begin
                alloc_en  = 1'b1;
                load_code = 1'b1;
                slot      = rel_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                alloc_en  = 1'b1;
                load_code = 1'b1;
                steal_adv = 1'b1;
                slot      = steal_ptr;
`else
                drop      = 1'b1;
`endif
            end
        end
    end

    // Release countdown runs first; a table operation on the same slot overrides it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            voice_gate <= '0;
            voice_busy <= '0;
            voice_code <= '0;
            overflow   <= 1'b0;
            Amplitude  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) rel_cnt[i] <= '0;
        end else begin
            overflow  <= drop;
            Amplitude <= (|voice_gate) ? AMP_ON : 32'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_busy[i] && !voice_gate[i]) begin
                    if (rel_cnt[i] == '0) voice_busy[i] <= 1'b0;
                    else                  rel_cnt[i]    <= rel_cnt[i] - 1'b1;
                end
            end
            if (alloc_en) begin
                voice_gate[slot] <= 1'b1;
                voice_busy[slot] <= 1'b1;
                rel_cnt[slot]    <= '0;
                if (load_code) voice_code[8*int'(slot) +: 8] <= keyboard_data;
            end
            if (break_ev && gated_hit) begin
                voice_gate[gated_idx] <= 1'b0;
                rel_cnt[gated_idx]    <= REL_LOAD;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            steal_ptr <= '0;
        else if (steal_adv)
            steal_ptr <= (steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
    end
`else
    logic unused_steal;
    assign unused_steal = steal_adv;
`endif
endmodule

// File: tb/tb_keyboard_voice_allocator.sv
// tb/tb_keyboard_voice_allocator.sv - scoreboard bench for keyboard_voice_allocator (RELEASE_CYCLES=16)
module tb_keyboard_voice_allocator;
    localparam logic [31:0] AMP = 32'd5000000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [7:0]  keyboard_data;
    logic        data_received_en;
    logic [3:0]  voice_gate, voice_busy;
    logic [31:0] voice_code;
    logic        overflow;
    logic [31:0] Amplitude;

    keyboard_voice_allocator #(
        .NUM_VOICES(4), .AMP_ON(AMP), .RELEASE_CYCLES(16)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .keyboard_data(keyboard_data),
        .data_received_en(data_received_en), .voice_gate(voice_gate), .voice_busy(voice_busy),
        .voice_code(voice_code), .overflow(overflow), .Amplitude(Amplitude)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          kind;
        string       name;
        logic [3:0]  gate;
        logic [3:0]  busy;
        logic [31:0] code;
        logic        ovf;
        logic [31:0] amp;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic push_tab(input string nm, input int at, input logic [3:0] g, input logic [3:0] b,
                            input logic [31:0] c, input logic o);
        exp_t e;
        e.at = at; e.kind = 0; e.name = nm; e.gate = g; e.busy = b; e.code = c; e.ovf = o; e.amp = '0;
        q.push_back(e);
    endtask

    task automatic push_amp(input string nm, input int at, input logic [31:0] a);
        exp_t e;
        e.at = at; e.kind = 1; e.name = nm; e.gate = '0; e.busy = '0; e.code = '0; e.ovf = 1'b0; e.amp = a;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        keyboard_data    = b;
        data_received_en = 1'b1;
        @(negedge CLOCK_50);
        data_received_en = 1'b0;
        keyboard_data    = 8'hF0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLOCK_50);
    endtask

    // Monitor: pops every expectation due at this cycle and compares it.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            #2;
            while (q.size() > 0 && q[0].at <= cyc) begin
                automatic exp_t e = q.pop_front();
                n_cmp++;
                if (e.at < cyc) begin
                    n_bad++;
                    $display("FAIL %s: missed check cycle %0d (now %0d)", e.name, e.at, cyc);
                end else if (e.kind == 0) begin
                    if ({voice_gate, voice_busy, voice_code, overflow} !== {e.gate, e.busy, e.code, e.ovf}) begin
                        n_bad++;
                        $display("FAIL %s: got gate=%b busy=%b code=%h ovf=%b, want gate=%b busy=%b code=%h ovf=%b",
                                 e.name, voice_gate, voice_busy, voice_code, overflow, e.gate, e.busy, e.code, e.ovf);
                    end
                end else begin
                    if (Amplitude !== e.amp) begin
                        n_bad++;
                        $display("FAIL %s: got Amplitude=%0d, want %0d", e.name, Amplitude, e.amp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1; data_received_en = 1'b0; keyboard_data = 8'h00;
        repeat (2) @(negedge CLOCK_50);
        push_tab("reset", cyc, 4'h0, 4'h0, 32'h0, 1'b0);
        push_amp("reset_amp", cyc, 32'd0);
        reset = 1'b0;
        idle(1);

        // Single make: table after 1 clk, Amplitude after 2
        send(8'h1C); t = cyc;
        push_tab("t1_make", t, 4'h1, 4'h1, 32'h0000001C, 1'b0);
        push_amp("t1_amp_1clk", t, 32'd0);
        push_amp("t1_amp_2clk", t + 1, AMP);

        // Break then 16-cycle release, code retained after expiry
        send(8'hF0); send(8'h1C); t = cyc;
        push_tab("t2_break", t, 4'h0, 4'h1, 32'h0000001C, 1'b0);
        push_amp("t2_amp_off", t + 1, 32'd0);
        push_tab("t2_rel_last", t + 15, 4'h0, 4'h1, 32'h0000001C, 1'b0);
        push_tab("t2_rel_done", t + 16, 4'h0, 4'h0, 32'h0000001C, 1'b0);
        wait_until(t + 17);

        // Fill all four voices, then a typematic repeat
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        push_tab("t3_four", cyc, 4'hF, 4'hF, 32'h2B231B1C, 1'b0);
        send(8'h1C);
        push_tab("t3_repeat", cyc, 4'hF, 4'hF, 32'h2B231B1C, 1'b0);

        // All gated: overflow or steal
        send(8'h34); t = cyc;
`ifdef VOICE_STEAL_EN
        push_tab("t4_steal0", t, 4'hF, 4'hF, 32'h2B231B34, 1'b0);
        send(8'h35);
        push_tab("t4_steal1", cyc, 4'hF, 4'hF, 32'h2B233534, 1'b0);
`else
        push_tab("t4_overflow", t, 4'hF, 4'hF, 32'h2B231B1C, 1'b1);
        push_tab("t4_ovf_clear", t + 1, 4'hF, 4'hF, 32'h2B231B1C, 1'b0);
`endif
        idle(1);
        reset = 1'b1;
        idle(1);
        push_tab("t4_reset", cyc, 4'h0, 4'h0, 32'h0, 1'b0);
        push_amp("t4_reset_amp", cyc, 32'd0);
        reset = 1'b0;

        // Extended make/break are not voiced; parser returns to idle
        send(8'hE0); send(8'h75);
        push_tab("t5_ext_make", cyc, 4'h0, 4'h0, 32'h0, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75);
        push_tab("t5_ext_break", cyc, 4'h0, 4'h0, 32'h0, 1'b0);
        send(8'h1C);
        push_tab("t5_after_ext", cyc, 4'h1, 4'h1, 32'h0000001C, 1'b0);

        // Re-gate mid-release: voice0 must not expire later
        send(8'h1B);
        push_tab("t6_alloc", cyc, 4'h3, 4'h3, 32'h00001B1C, 1'b0);
        send(8'hF0); send(8'h1C); t = cyc;
        push_tab("t6_break", t, 4'h2, 4'h3, 32'h00001B1C, 1'b0);
        idle(3);
        send(8'h1C);
        push_tab("t6_regate", cyc, 4'h3, 4'h3, 32'h00001B1C, 1'b0);
        push_tab("t6_no_expiry", t + 16, 4'h3, 4'h3, 32'h00001B1C, 1'b0);
        wait_until(t + 17);

        // A second break while releasing must not restart the countdown
        send(8'hF0); send(8'h1C); t = cyc;
        push_tab("t6_break2", t, 4'h2, 4'h3, 32'h00001B1C, 1'b0);
        push_tab("t6_rel_last2", t + 15, 4'h2, 4'h3, 32'h00001B1C, 1'b0);
        push_tab("t6_expire2", t + 16, 4'h2, 4'h2, 32'h00001B1C, 1'b0);
        idle(5);
        send(8'hF0); send(8'h1C);
        wait_until(t + 17);

        // Reset during release clears everything on the next edge
        send(8'hF0); send(8'h1B); t = cyc;
        push_tab("t6_break_1b", t, 4'h0, 4'h2, 32'h00001B1C, 1'b0);
        push_amp("t6_amp_off", t + 1, 32'd0);
        idle(3);
        reset = 1'b1;
        idle(1);
        push_tab("t6_reset_mid_release", cyc, 4'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b0;
        idle(3);

        while (q.size() > 0) begin
            automatic exp_t e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared (due cycle %0d)", e.name, e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
